imm_extend_pipe: RTL

Pipelined, parametrised immediate generator for the microprocessor datapath, successor to the single-cycle immediate extension logic. It takes the 24-bit instruction immediate field and the 2-bit op class and produces a DATA_W-wide operand. It adds ARM-style rotated data-processing immediates, a valid/ready handshake with backpressure, a flush port, and an optional prefix mode that builds wide constants across several instructions. It sits between the decode stage and the operand mux of the execute stage.

---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_rotator.sv | 18 +
 rtl/imm_extend_pipe.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Also holds the prefix-state enum used when IMM_PREFIX_EN is defined.
package imm_pkg;

    localparam int unsigned IMM_FIELD_W = 24;
    localparam int unsigned ROT_SHIFT_W = 4;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_PFX = 2'b11
    } op_class_e;

    typedef enum logic {
        PfxIdle,
        PfxArmed
    } pfx_state_e;

endpackage

// File: rtl/imm_rotator.sv
// Combinational 32-bit rotate-right by twice the 4-bit rotate field.
module imm_rotator
    import imm_pkg::*;
(
    input  logic [31:0]            data,
    input  logic [ROT_SHIFT_W-1:0] rot,
    output logic [31:0]            result
);

    logic [4:0] amount;

    // Shift a doubled copy so the bits leaving the bottom wrap in at the top.
    always_comb begin
        amount = {rot, 1'b0};
        result = 32'({data, data} >> amount);
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate generator: S1 registers the decoded beat and tracks prefix
// state; S2 extends/rotates and holds the output beat under backpressure.
// Optional feature macro: IMM_PREFIX_EN (op 11 builds wide constants across beats).
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [IMM_FIELD_W-1:0] in_imm24,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_imm,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_prefixed,
    output logic                   out_err
);

    logic                   s1_valid;
    op_class_e              s1_op;
    logic [IMM_FIELD_W-1:0] s1_imm;
    logic [TAG_W-1:0]       s1_tag;

    logic                   s2_free;
    logic                   accept;
    logic                   s1_drop;
    logic                   s2_load;

    logic [31:0]            rot_out;
    logic [DATA_W-1:0]      s2_imm;
    logic                   s2_err;
    logic                   s2_pfx;

    // Handshake: S1 can take a beat when empty or when its beat moves on to S2.
    always_comb begin
        s2_free  = !out_valid || out_ready;
        in_ready = !flush && (!s1_valid || s2_free);
        accept   = in_valid && in_ready;
        s2_load  = s1_valid && !s1_drop;
    end

    // Stage 1 register: capture the accepted beat, empty when it drains to S2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_DP;
            s1_imm   <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= op_class_e'(in_op);
            s1_imm   <= in_imm24;
            s1_tag   <= in_tag;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

`ifdef IMM_PREFIX_EN
    pfx_state_e        pfx_state_q, pfx_state_d;
    logic [DATA_W-1:0] pfx_acc_q, pfx_acc_d;
    logic              s1_pfx_hit;
    logic [DATA_W-1:0] s1_pfx_acc;

    // Prefix beats occupy S1 for a cycle but never reach the output.
    always_comb begin
        s1_drop = (s1_op == OP_PFX);
    end

    // Prefix FSM next state: accumulate on prefix, consume on the next real beat.
    always_comb begin
        pfx_state_d = pfx_state_q;
        pfx_acc_d   = pfx_acc_q;
        if (flush) begin
            pfx_state_d = PfxIdle;
            pfx_acc_d   = '0;
        end else if (accept) begin
            if (in_op == OP_PFX) begin
                pfx_state_d = PfxArmed;
                pfx_acc_d   = (pfx_acc_q << IMM_FIELD_W) | DATA_W'(in_imm24);
            end else begin
                unique case (pfx_state_q)
                    PfxArmed: begin
                        pfx_state_d = PfxIdle;
                        pfx_acc_d   = '0;
                    end
                    PfxIdle: ;
                    default: ;
                endcase
            end
        end
    end

    // Prefix FSM state and accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pfx_state_q <= PfxIdle;
            pfx_acc_q   <= '0;
        end else begin
            pfx_state_q <= pfx_state_d;
            pfx_acc_q   <= pfx_acc_d;
        end
    end

    // Snapshot of the accumulator travelling with the beat that consumes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_pfx_hit <= 1'b0;
            s1_pfx_acc <= '0;
        end else if (accept) begin
            s1_pfx_hit <= (in_op != OP_PFX) && (pfx_state_q == PfxArmed);
            s1_pfx_acc <= pfx_acc_q;
        end
    end
`else
    // Without prefix support every S1 beat produces an output beat.
    always_comb begin
        s1_drop = 1'b0;
    end
`endif

    imm_rotator u_rotator (
        .data   ({24'b0, s1_imm[7:0]}),
        .rot    (s1_imm[11:8]),
        .result (rot_out)
    );

    // Stage 2 datapath: select the extension rule for the S1 beat.
    always_comb begin
        s2_imm = '0;
        s2_err = 1'b0;
        s2_pfx = 1'b0;
        case (s1_op)
            OP_DP:   s2_imm = DATA_W'(rot_out);
            OP_MEM:  s2_imm = DATA_W'(s1_imm[11:0]);
            OP_BR:   s2_imm = {{(DATA_W - 26){s1_imm[23]}}, s1_imm, 2'b00};
`ifdef IMM_PREFIX_EN
            OP_PFX:  s2_imm = '0;
`else
            OP_PFX:  s2_err = 1'b1;
`endif
            default: s2_imm = '0;
        endcase
`ifdef IMM_PREFIX_EN
        // A prefixed beat overrides the op-class rule entirely.
        if (s1_pfx_hit) begin
            s2_imm = (s1_pfx_acc << 8) | DATA_W'(s1_imm[7:0]);
            s2_pfx = 1'b1;
        end
`endif
    end

    // Stage 2 output register: hold while stalled, flush drops a held beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s2_load;
            if (s2_load) begin
                out_imm <= s2_imm;
                out_tag <= s1_tag;
                out_err <= s2_err;
            end
        end
    end

`ifdef IMM_PREFIX_EN
    // Prefixed flag follows the same load rule as the rest of the output beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_prefixed <= 1'b0;
        end else if (!flush && s2_free && s2_load) begin
            out_prefixed <= s2_pfx;
        end
    end
`else
    assign out_prefixed = s2_pfx;
`endif

endmodule
